// File: rtl/debouncer_multi.sv
// Multi-channel button conditioner: per-channel two-flop synchroniser, stability
// counter, debounced level, press/release pulses and long-press / auto-repeat pulses.
module debouncer_multi #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 0,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_buttons,
    output logic [N_CH-1:0] o_state,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_hold,
    output logic            o_any_press
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = (REPEAT_CYCLES > 0) ? HW'(REPEAT_CYCLES - 1) : '0;

    typedef enum logic {PH_FIRST, PH_REPEAT} phase_t;

    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] state_q, state_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] hold_q, hold_d;
    logic            any_press_q;
    logic [DW-1:0]   cnt_q  [N_CH];
    logic [DW-1:0]   cnt_d  [N_CH];
    logic [HW-1:0]   hcnt_q [N_CH];
    logic [HW-1:0]   hcnt_d [N_CH];
    phase_t          phase_q[N_CH];
    phase_t          phase_d[N_CH];

    assign raw = (ACTIVE_LOW != 0) ? ~i_buttons : i_buttons;

    always_comb begin
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        hold_d    = '0;
        for (int k = 0; k < N_CH; k++) begin
            cnt_d[k]   = cnt_q[k];
            hcnt_d[k]  = hcnt_q[k];
            phase_d[k] = phase_q[k];

            if (sync2_q[k] == state_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == DEB_LAST) begin
                cnt_d[k]     = '0;
                state_d[k]   = ~state_q[k];
                press_d[k]   = ~state_q[k];
                release_d[k] = state_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end

            // Keyed on the next level so a release edge suppresses any pulse due that cycle;
            // counting starts only once the high level has been visible for one cycle.
            if (!state_d[k]) begin
                hcnt_d[k]  = '0;
                phase_d[k] = PH_FIRST;
            end else if (state_q[k]) begin
                if (phase_q[k] == PH_FIRST) begin
                    if (hcnt_q[k] == HOLD_LAST) begin
                        hold_d[k]  = 1'b1;
                        hcnt_d[k]  = '0;
                        phase_d[k] = PH_REPEAT;
                    end else begin
                        hcnt_d[k] = hcnt_q[k] + 1'b1;
                    end
                end else if (REPEAT_CYCLES > 0) begin
                    if (hcnt_q[k] == REP_LAST) begin
                        hold_d[k] = 1'b1;
                        hcnt_d[k] = '0;
                    end else begin
                        hcnt_d[k] = hcnt_q[k] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            hold_q      <= '0;
            any_press_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k]   <= '0;
                hcnt_q[k]  <= '0;
                phase_q[k] <= PH_FIRST;
            end
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            hold_q      <= hold_d;
            any_press_q <= |press_d;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k]   <= cnt_d[k];
                hcnt_q[k]  <= hcnt_d[k];
                phase_q[k] <= phase_d[k];
            end
        end
    end

    assign o_state     = state_q;
    assign o_press     = press_q;
    assign o_release   = release_q;
    assign o_hold      = hold_q;
    assign o_any_press = any_press_q;
endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: three instances (repeat, single-hold, active-low)
// with predicted pulse events queued by cycle and matched as the outputs appear.
module tb_debouncer_multi;
    localparam int EW   = 65;
    localparam int F_AR = 0;
    localparam int F_AP = 4;
    localparam int F_RH = 8;
    localparam int F_RR = 12;
    localparam int F_RP = 16;
    localparam int F_MH = 21;
    localparam int F_MR = 25;
    localparam int F_MP = 29;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_m, btn_r, btn_a;
    logic [3:0] m_state, m_press, m_rel, m_hold;
    logic [3:0] r_state, r_press, r_rel, r_hold;
    logic [3:0] a_state, a_press, a_rel, a_hold;
    logic       m_any, r_any, a_any;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debouncer_multi #(.N_CH(4), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .ACTIVE_LOW(0)) dut_m (
        .i_clk(clk), .i_rst(rst), .i_buttons(btn_m), .o_state(m_state), .o_press(m_press),
        .o_release(m_rel), .o_hold(m_hold), .o_any_press(m_any));
    debouncer_multi #(.N_CH(4), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(20), .REPEAT_CYCLES(0), .ACTIVE_LOW(0)) dut_r (
        .i_clk(clk), .i_rst(rst), .i_buttons(btn_r), .o_state(r_state), .o_press(r_press),
        .o_release(r_rel), .o_hold(r_hold), .o_any_press(r_any));
    debouncer_multi #(.N_CH(4), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .ACTIVE_LOW(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_buttons(btn_a), .o_state(a_state), .o_press(a_press),
        .o_release(a_rel), .o_hold(a_hold), .o_any_press(a_any));

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Insert one predicted pulse, merging with anything already due in the same cycle.
    task automatic exp_event(input int c, input int off, input logic [3:0] m);
        logic [EW-1:0] e;
        bit done;
        e = '0;
        e[64:33] = c;
        e = e | (EW'(m) << off);
        if (off == F_MP) e[20] = 1'b1;
        done = 1'b0;
        for (int i = 0; i < exp_q.size() && !done; i++) begin
            if (exp_q[i][64:33] == e[64:33]) begin
                exp_q[i] = exp_q[i] | e;
                done = 1'b1;
            end else if (exp_q[i][64:33] > e[64:33]) begin
                exp_q.insert(i, e);
                done = 1'b1;
            end
        end
        if (!done) exp_q.push_back(e);
    endtask

    // Hold pulses for a press at edge p that ends (release or reset) at edge stop.
    task automatic expect_holds(input int off, input logic [3:0] m, input int p, input int stop, input int rep);
        int c;
        c = p + 20;
        while (c < stop) begin
            exp_event(c, off, m);
            if (rep == 0) break;
            c = c + rep;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] obs;
        logic [EW-1:0] exp;
        obs = {cyc[31:0], m_press, m_rel, m_hold, m_any, r_press, r_rel, r_hold, a_press, a_rel};
        if (obs[32:0] !== 33'b0 || (exp_q.size() > 0 && exp_q[0][64:33] == cyc[31:0])) begin
            if (exp_q.size() > 0 && exp_q[0][64:33] == cyc[31:0]) exp = exp_q.pop_front();
            else exp = {cyc[31:0], 33'b0};
            chk("event", obs, exp);
        end
    end

    initial begin
        int t, p, p1, p2;
        rst = 1'b1;
        btn_m = 4'h0;
        btn_r = 4'h0;
        btn_a = 4'hF;
        wait_until(3);
        rst = 1'b0;
        wait_until(5);
        chk("rst_m_state", EW'(m_state), EW'(4'h0));
        chk("rst_m_pulses", EW'({m_press, m_rel, m_hold, m_any}), EW'(0));
        chk("rst_r_outputs", EW'({r_state, r_any}), EW'(0));
        chk("rst_a_idle", EW'({a_state, a_hold, a_any}), EW'(0));

        // Clean press on ch0; release lands exactly where the first hold would be.
        t = cyc;
        btn_m[0] = 1'b1;
        p = t + 10;
        exp_event(p, F_MP, 4'b0001);
        exp_event(p + 20, F_MR, 4'b0001);
        wait_until(p);
        chk("press_state", EW'({m_state, m_press, m_any}), EW'({4'b0001, 4'b0001, 1'b1}));
        wait_until(p + 1);
        chk("press_one_cycle", EW'({m_state, m_press, m_any}), EW'({4'b0001, 4'b0000, 1'b0}));
        wait_until(t + 20);
        btn_m[0] = 1'b0;
        wait_until(p + 20);
        chk("release_no_hold", EW'({m_state, m_rel, m_hold}), EW'({4'b0000, 4'b0001, 4'b0000}));
        wait_until(p + 24);

        // Bounce on ch1, then stable high.
        for (int i = 0; i < 40; i++) begin
            btn_m[1] = ((i / 3) % 2 == 0);
            @(posedge clk);
            #1;
        end
        btn_m[1] = 1'b1;
        t = cyc;
        p = t + 10;
        exp_event(p, F_MP, 4'b0010);
        expect_holds(F_MH, 4'b0010, p, p + 22, 5);
        exp_event(p + 22, F_MR, 4'b0010);
        wait_until(p + 12);
        btn_m[1] = 1'b0;
        wait_until(p + 25);

        // Long press on ch2 with auto-repeat, and the single-hold instance alongside.
        t = cyc;
        btn_m[2] = 1'b1;
        btn_r[2] = 1'b1;
        p = t + 10;
        exp_event(p, F_MP, 4'b0100);
        exp_event(p, F_RP, 4'b0100);
        expect_holds(F_MH, 4'b0100, p, p + 40, 5);
        expect_holds(F_RH, 4'b0100, p, p + 40, 0);
        exp_event(p + 40, F_MR, 4'b0100);
        exp_event(p + 40, F_RR, 4'b0100);
        wait_until(p);
        chk("r_state_press", EW'(r_state), EW'(4'b0100));
        wait_until(p + 30);
        btn_m[2] = 1'b0;
        btn_r[2] = 1'b0;
        wait_until(p + 40);
        chk("repeat_cancel", EW'({m_state, m_rel, m_hold}), EW'({4'b0000, 4'b0100, 4'b0000}));
        wait_until(p + 43);

        // Simultaneous press of ch0/ch3 with release of ch1.
        t = cyc;
        btn_m[1] = 1'b1;
        p1 = t + 10;
        exp_event(p1, F_MP, 4'b0010);
        wait_until(p1 + 2);
        btn_m = 4'b1001;
        exp_event(p1 + 12, F_MP, 4'b1001);
        exp_event(p1 + 12, F_MR, 4'b0010);
        wait_until(p1 + 12);
        chk("simul_edges", EW'({m_press, m_rel, m_state}), EW'({4'b1001, 4'b0010, 4'b1001}));
        btn_m = 4'b0000;
        exp_event(p1 + 22, F_MR, 4'b1001);
        wait_until(p1 + 25);

        // Reset while ch0 is mid-debounce and ch2 is mid-hold; pins stay active.
        t = cyc;
        btn_m[2] = 1'b1;
        p2 = t + 10;
        exp_event(p2, F_MP, 4'b0100);
        wait_until(p2 + 8);
        btn_m[0] = 1'b1;
        wait_until(p2 + 15);
        rst = 1'b1;
        wait_until(p2 + 16);
        rst = 1'b0;
        chk("mid_reset_clear", EW'({m_state, m_press, m_rel, m_hold, m_any}), EW'(0));
        exp_event(p2 + 26, F_MP, 4'b0101);
        wait_until(p2 + 26);
        chk("post_reset_state", EW'(m_state), EW'(4'b0101));
        wait_until(p2 + 30);
        btn_m = 4'b0000;
        exp_event(p2 + 40, F_MR, 4'b0101);
        wait_until(p2 + 43);

        // Active-low pins.
        t = cyc;
        btn_a[0] = 1'b0;
        exp_event(t + 10, F_AP, 4'b0001);
        wait_until(t + 10);
        chk("al_press", EW'({a_state, a_any}), EW'({4'b0001, 1'b1}));
        wait_until(t + 12);
        btn_a[0] = 1'b1;
        exp_event(t + 22, F_AR, 4'b0001);
        wait_until(t + 26);
        chk("al_idle", EW'({a_state, a_hold}), EW'(0));

        chk("queue_drained", EW'(exp_q.size()), EW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
